wb_sched: RTL and testbench

- Writeback-stage scheduler for the 64-bit core.
- Accepts one retiring instruction per handshake and drives the 3-bit writeback-source select (rd_m) of the rd source mux.
- Generates register-file write enable/address and sequences loads by holding until the data-memory response arrives.
- Provides back-pressure to the memory stage, a flush path, and a retire counter.

---
 rtl/wb_pkg.sv | 36 +++
 rtl/wb_sched.sv | 101 ++++++++++
 tb/tb_wb_sched.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared types for the writeback scheduler: rd source select encoding, FSM states, helpers.
package wb_pkg;

   localparam int unsigned RDM_W    = 3;
   localparam int unsigned REG_ZERO = 0;

   typedef enum logic [RDM_W-1:0] {
      RDM_ALU  = 3'd0,
      RDM_PC4  = 3'd1,
      RDM_SEXT = 3'd2,
      RDM_BR   = 3'd3,
      RDM_DMEM = 3'd4
   } rdm_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WRITE    = 2'd1,
      WAIT_MEM = 2'd2
   } wb_state_t;

   function automatic logic rdm_legal(input logic [RDM_W-1:0] raw);
      return raw <= RDM_W'(RDM_DMEM);
   endfunction

   // Illegal encodings fall back to the ALU source, as the mux default does.
   function automatic rdm_t decode_rdm(input logic [RDM_W-1:0] raw);
      case (raw)
         3'd1:    return RDM_PC4;
         3'd2:    return RDM_SEXT;
         3'd3:    return RDM_BR;
         3'd4:    return RDM_DMEM;
         default: return RDM_ALU;
      endcase
   endfunction

endpackage

// File: rtl/wb_sched.sv
// Writeback-stage scheduler: rd source select, RF write strobe, load sequencing, retire counter.
// Optional load-use forwarding hint outputs are enabled with `define WB_FWD_EN.
module wb_sched
   import wb_pkg::*;
#(
   parameter int unsigned REG_AW = 5,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [REG_AW-1:0] in_rd,
   input  logic [RDM_W-1:0]  in_rdm,
   input  logic              dmem_data_ok,
   input  logic              flush,
   output logic [RDM_W-1:0]  rdm_sel,
   output logic              rf_wen,
   output logic [REG_AW-1:0] rf_waddr,
   output logic              retire_pulse,
   output logic [CNT_W-1:0]  retire_cnt,
   output logic              err_rdm
`ifdef WB_FWD_EN
   ,
   output logic              fwd_pend,
   output logic [REG_AW-1:0] fwd_rd
`endif
);

   wb_state_t         state;
   logic [REG_AW-1:0] cap_rd;
   rdm_t              cap_rdm;
   logic              rd_nz;
   logic              xfer;

   // Output decode from registered state; flush squashes the write and retire of this cycle.
   always_comb begin
      in_ready     = 1'b0;
      rdm_sel      = RDM_W'(RDM_ALU);
      rf_wen       = 1'b0;
      rf_waddr     = '0;
      retire_pulse = 1'b0;
      rd_nz        = (cap_rd != REG_AW'(REG_ZERO));
      case (state)
         IDLE: begin
            in_ready = reset;
         end
         WRITE: begin
            in_ready     = reset;
            rdm_sel      = cap_rdm;
            rf_waddr     = cap_rd;
            rf_wen       = rd_nz && !flush;
            retire_pulse = !flush;
         end
         WAIT_MEM: begin
            rdm_sel      = RDM_W'(RDM_DMEM);
            rf_waddr     = cap_rd;
            rf_wen       = dmem_data_ok && rd_nz && !flush;
            retire_pulse = dmem_data_ok && !flush;
         end
         default: ;
      endcase
      xfer = in_valid && in_ready && !flush;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         cap_rd     <= '0;
         cap_rdm    <= RDM_ALU;
         retire_cnt <= '0;
         err_rdm    <= 1'b0;
      end else begin
         if (retire_pulse) retire_cnt <= retire_cnt + CNT_W'(1);
         if (xfer) begin
            cap_rd  <= in_rd;
            cap_rdm <= decode_rdm(in_rdm);
            if (!rdm_legal(in_rdm)) err_rdm <= 1'b1;
         end
         case (state)
            IDLE, WRITE: begin
               if (xfer) state <= (in_rdm == RDM_W'(RDM_DMEM)) ? WAIT_MEM : WRITE;
               else      state <= IDLE;
            end
            WAIT_MEM: begin
               if (flush || dmem_data_ok) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef WB_FWD_EN
   // Pending load destination, so decode can stall on a load-use hazard.
   always_comb begin
      fwd_pend = (state == WAIT_MEM) && rd_nz;
      fwd_rd   = (state == WAIT_MEM) ? cap_rd : '0;
   end
`endif

endmodule

// File: tb/tb_wb_sched.sv
// Directed self-checking bench for wb_sched; define WB_FWD_EN to also cover the forwarding outputs.
module tb_wb_sched;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic [4:0] in_rd;
   logic [2:0] in_rdm;
   logic       dmem_data_ok;
   logic       flush;
   logic [2:0] rdm_sel;
   logic       rf_wen;
   logic [4:0] rf_waddr;
   logic       retire_pulse;
   logic [15:0] retire_cnt;
   logic       err_rdm;
`ifdef WB_FWD_EN
   logic       fwd_pend;
   logic [4:0] fwd_rd;
`endif

   int checks = 0;
   int errors = 0;
   int exp_cnt = 0;

   wb_sched #(.REG_AW(5), .CNT_W(16)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_rdm(in_rdm),
      .dmem_data_ok(dmem_data_ok), .flush(flush),
      .rdm_sel(rdm_sel), .rf_wen(rf_wen), .rf_waddr(rf_waddr),
      .retire_pulse(retire_pulse), .retire_cnt(retire_cnt), .err_rdm(err_rdm)
`ifdef WB_FWD_EN
      , .fwd_pend(fwd_pend), .fwd_rd(fwd_rd)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish, got running want done");
      $fatal(1, "timeout");
   end

   // Advance to just after the next rising edge; inputs change there.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [4:0] rd, input logic [2:0] rdm);
      in_valid = v;
      in_rd    = rd;
      in_rdm   = rdm;
   endtask

   // {in_ready, rf_wen, rdm_sel, rf_waddr, retire_pulse} packs to 11 bits
   task automatic test_reset();
      reset = 1'b0; dmem_data_ok = 1'b0; flush = 1'b0;
      drive(1'b0, 5'd0, 3'd0);
      @(negedge clk);
      checks++;
      if ({in_ready, rf_wen, rdm_sel, rf_waddr, retire_pulse, retire_cnt, err_rdm} !== 28'd0) begin
         errors++;
         $display("FAIL reset_outputs: got %h want 0",
                  {in_ready, rf_wen, rdm_sel, rf_waddr, retire_pulse, retire_cnt, err_rdm});
      end
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL reset_release_ready: got %b want 1", in_ready);
      end
      next_cycle();
      drive(1'b1, 5'd5, 3'd4);
      next_cycle();
      drive(1'b0, 5'd0, 3'd0);
      @(negedge clk);
      checks++;
      if ({in_ready, rf_wen, rdm_sel, rf_waddr, retire_pulse} !== {1'b0, 1'b0, 3'd4, 5'd5, 1'b0}) begin
         errors++;
         $display("FAIL reset_wait_mem: got %h want %h",
                  {in_ready, rf_wen, rdm_sel, rf_waddr, retire_pulse}, {1'b0, 1'b0, 3'd4, 5'd5, 1'b0});
      end
      #1;
      dmem_data_ok = 1'b1;
      reset = 1'b0;
      #1;
      checks++;
      if ({in_ready, rf_wen, rdm_sel, rf_waddr, retire_pulse, retire_cnt, err_rdm} !== 28'd0) begin
         errors++;
         $display("FAIL reset_mid_load: got %h want 0",
                  {in_ready, rf_wen, rdm_sel, rf_waddr, retire_pulse, retire_cnt, err_rdm});
      end
      @(posedge clk); #1;
      dmem_data_ok = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if ({in_ready, rf_wen, rf_waddr, retire_cnt} !== {1'b1, 1'b0, 5'd0, 16'd0}) begin
         errors++;
         $display("FAIL reset_idle_after: got %h want %h",
                  {in_ready, rf_wen, rf_waddr, retire_cnt}, {1'b1, 1'b0, 5'd0, 16'd0});
      end
      next_cycle();
   endtask

   task automatic test_alu_back_to_back();
      drive(1'b1, 5'd1, 3'd0);
      for (int i = 1; i <= 3; i++) begin
         next_cycle();
         if (i < 3) drive(1'b1, 5'(i + 1), 3'd0);
         else       drive(1'b0, 5'd0, 3'd0);
         @(negedge clk);
         checks++;
         if ({in_ready, rf_wen, rdm_sel, rf_waddr, retire_pulse} !== {1'b1, 1'b1, 3'd0, 5'(i), 1'b1}) begin
            errors++;
            $display("FAIL alu_b2b_%0d: got %h want %h", i,
                     {in_ready, rf_wen, rdm_sel, rf_waddr, retire_pulse}, {1'b1, 1'b1, 3'd0, 5'(i), 1'b1});
         end
      end
      exp_cnt += 3;
      next_cycle();
      @(negedge clk);
      checks++;
      if ({rf_wen, retire_cnt} !== {1'b0, 16'(exp_cnt)}) begin
         errors++;
         $display("FAIL alu_b2b_cnt: got %h want %h", {rf_wen, retire_cnt}, {1'b0, 16'(exp_cnt)});
      end
      next_cycle();
   endtask

   task automatic test_load();
      drive(1'b1, 5'd7, 3'd4);
      next_cycle();
      drive(1'b0, 5'd0, 3'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if ({in_ready, rf_wen, retire_pulse} !== 3'b000) begin
            errors++;
            $display("FAIL load_wait_%0d: got %b want 000", i, {in_ready, rf_wen, retire_pulse});
         end
         next_cycle();
      end
      dmem_data_ok = 1'b1;
      @(negedge clk);
      checks++;
      if ({in_ready, rf_wen, rdm_sel, rf_waddr, retire_pulse} !== {1'b0, 1'b1, 3'd4, 5'd7, 1'b1}) begin
         errors++;
         $display("FAIL load_data_ok: got %h want %h",
                  {in_ready, rf_wen, rdm_sel, rf_waddr, retire_pulse}, {1'b0, 1'b1, 3'd4, 5'd7, 1'b1});
      end
      exp_cnt += 1;
      next_cycle();
      dmem_data_ok = 1'b0;
      @(negedge clk);
      checks++;
      if ({in_ready, rf_wen, retire_cnt} !== {1'b1, 1'b0, 16'(exp_cnt)}) begin
         errors++;
         $display("FAIL load_idle: got %h want %h", {in_ready, rf_wen, retire_cnt}, {1'b1, 1'b0, 16'(exp_cnt)});
      end
      next_cycle();
   endtask

   task automatic test_x0_illegal();
      drive(1'b1, 5'd0, 3'd1);
      next_cycle();
      drive(1'b1, 5'd4, 3'd6);
      @(negedge clk);
      checks++;
      if ({rf_wen, retire_pulse, rdm_sel, err_rdm} !== {1'b0, 1'b1, 3'd1, 1'b0}) begin
         errors++;
         $display("FAIL x0_write: got %h want %h", {rf_wen, retire_pulse, rdm_sel, err_rdm}, {1'b0, 1'b1, 3'd1, 1'b0});
      end
      next_cycle();
      drive(1'b0, 5'd0, 3'd0);
      @(negedge clk);
      checks++;
      if ({rf_wen, rf_waddr, rdm_sel, retire_pulse, err_rdm} !== {1'b1, 5'd4, 3'd0, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL illegal_rdm: got %h want %h",
                  {rf_wen, rf_waddr, rdm_sel, retire_pulse, err_rdm}, {1'b1, 5'd4, 3'd0, 1'b1, 1'b1});
      end
      exp_cnt += 2;
      next_cycle();
      next_cycle();
      @(negedge clk);
      checks++;
      if ({err_rdm, retire_cnt} !== {1'b1, 16'(exp_cnt)}) begin
         errors++;
         $display("FAIL err_sticky: got %h want %h", {err_rdm, retire_cnt}, {1'b1, 16'(exp_cnt)});
      end
      next_cycle();
   endtask

   task automatic test_flush();
      drive(1'b1, 5'd9, 3'd4);
      next_cycle();
      drive(1'b0, 5'd0, 3'd0);
      flush = 1'b1;
      dmem_data_ok = 1'b1;
      @(negedge clk);
      checks++;
      if ({rf_wen, retire_pulse} !== 2'b00) begin
         errors++; $display("FAIL flush_wait_mem: got %b want 00", {rf_wen, retire_pulse});
      end
      next_cycle();
      flush = 1'b0;
      dmem_data_ok = 1'b0;
      @(negedge clk);
      checks++;
      if ({in_ready, rf_wen, retire_cnt} !== {1'b1, 1'b0, 16'(exp_cnt)}) begin
         errors++;
         $display("FAIL flush_idle: got %h want %h", {in_ready, rf_wen, retire_cnt}, {1'b1, 1'b0, 16'(exp_cnt)});
      end
      next_cycle();
      drive(1'b1, 5'd3, 3'd0);
      next_cycle();
      drive(1'b1, 5'd8, 3'd0);
      flush = 1'b1;
      @(negedge clk);
      checks++;
      if ({in_ready, rf_wen, retire_pulse} !== 3'b100) begin
         errors++; $display("FAIL flush_write: got %b want 100", {in_ready, rf_wen, retire_pulse});
      end
      next_cycle();
      flush = 1'b0;
      drive(1'b0, 5'd0, 3'd0);
      @(negedge clk);
      checks++;
      if ({rf_wen, rf_waddr, retire_pulse, retire_cnt} !== {1'b0, 5'd0, 1'b0, 16'(exp_cnt)}) begin
         errors++;
         $display("FAIL flush_no_xfer: got %h want %h",
                  {rf_wen, rf_waddr, retire_pulse, retire_cnt}, {1'b0, 5'd0, 1'b0, 16'(exp_cnt)});
      end
      next_cycle();
   endtask

   task automatic test_fwd_load();
      drive(1'b1, 5'd12, 3'd4);
      next_cycle();
      drive(1'b0, 5'd0, 3'd0);
      @(negedge clk);
      checks++;
      if ({in_ready, rf_waddr} !== {1'b0, 5'd12}) begin
         errors++; $display("FAIL fwd_load_wait: got %h want %h", {in_ready, rf_waddr}, {1'b0, 5'd12});
      end
`ifdef WB_FWD_EN
      checks++;
      if ({fwd_pend, fwd_rd} !== {1'b1, 5'd12}) begin
         errors++; $display("FAIL fwd_pending: got %h want %h", {fwd_pend, fwd_rd}, {1'b1, 5'd12});
      end
`endif
      next_cycle();
      dmem_data_ok = 1'b1;
      exp_cnt += 1;
      next_cycle();
      dmem_data_ok = 1'b0;
      @(negedge clk);
      checks++;
      if ({in_ready, retire_cnt} !== {1'b1, 16'(exp_cnt)}) begin
         errors++; $display("FAIL fwd_load_done: got %h want %h", {in_ready, retire_cnt}, {1'b1, 16'(exp_cnt)});
      end
`ifdef WB_FWD_EN
      checks++;
      if ({fwd_pend, fwd_rd} !== 6'd0) begin
         errors++; $display("FAIL fwd_cleared: got %h want 0", {fwd_pend, fwd_rd});
      end
`endif
      next_cycle();
   endtask

   task automatic test_counter_wrap();
      int k;
      k = 65535 - exp_cnt;
      drive(1'b1, 5'd1, 3'd0);
      for (int i = 0; i < k; i++) next_cycle();
      drive(1'b0, 5'd0, 3'd0);
      next_cycle();
      next_cycle();
      @(negedge clk);
      checks++;
      if (retire_cnt !== 16'hFFFF) begin
         errors++; $display("FAIL cnt_preload: got %h want ffff", retire_cnt);
      end
      next_cycle();
      drive(1'b1, 5'd2, 3'd0);
      next_cycle();
      drive(1'b0, 5'd0, 3'd0);
      next_cycle();
      @(negedge clk);
      checks++;
      if (retire_cnt !== 16'h0000) begin
         errors++; $display("FAIL cnt_wrap: got %h want 0000", retire_cnt);
      end
      next_cycle();
   endtask

   initial begin
      test_reset();
      test_alu_back_to_back();
      test_load();
      test_x0_illegal();
      test_flush();
      test_fwd_load();
      test_counter_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
